// File: rtl/hdmi_video_timing_ctrl.sv
// hdmi_video_timing_ctrl
//   Video timing generator and pixel scheduler in front of the VGA2HDMI TMDS
//   datapath. Programmable horizontal/vertical counters produce HSYNC, VSYNC
//   and ACTIVE. Pixels are pulled from an upstream source through a
//   valid/ready handshake. Starts and stops happen only on frame boundaries,
//   and a missing pixel is flagged as a sticky underrun.
//
// Ports
//   pixclk        pixel clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   enable        run request (level)
//   pix_data      {red,green,blue} from upstream
//   pix_valid     pix_data is valid
//   pix_ready     controller takes pix_data this cycle (combinational)
//   HSYNC/VSYNC   registered syncs, asserted level = SYNC_POL
//   ACTIVE        registered data enable
//   red/green/blue registered pixel aligned with ACTIVE
//   x_pos/y_pos   counter position of the pixel currently on the outputs
//   frame_start   one-cycle pulse with the first output cycle of each frame
//   underrun      sticky flag: pixel requested while pix_valid was low
//   underrun_clr  clears underrun (a simultaneous new underrun wins)
module hdmi_video_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        pixclk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        ACTIVE,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic [10:0] x_pos,
    output logic [10:0] y_pos,
    output logic        frame_start,
    output logic        underrun,
    input  logic        underrun_clr
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_DE_END = 11'(H_ACTIVE);
    localparam logic [10:0] V_DE_END = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic SYNC_ON = (SYNC_POL != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_last;
    logic        frame_last;
    logic        de;
    logic        hs;
    logic        vs;
    logic        live;

    // Region decode from the current counter position
    always_comb begin
        h_last     = (h_cnt == H_LAST);
        frame_last = h_last && (v_cnt == V_LAST);
        de         = (h_cnt < H_DE_END) && (v_cnt < V_DE_END);
        hs         = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        vs         = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    end

    // FSM: state register
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state. DRAIN ignores enable until the last pixel of the
    // frame, so a frame is never cut short.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (enable)     state_nxt = S_RUN;
            S_RUN:   if (!enable)    state_nxt = S_DRAIN;
            S_DRAIN: if (frame_last) state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        live      = (state != S_IDLE);
        pix_ready = de && live;
    end

    // Counters are held at the origin while idle, so a restart always begins
    // at (0,0). The wrap at the end of a drained frame lands them there too.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!live) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    // Registered video outputs, one pixclk behind the counters
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            ACTIVE      <= 1'b0;
            HSYNC       <= ~SYNC_ON;
            VSYNC       <= ~SYNC_ON;
            x_pos       <= '0;
            y_pos       <= '0;
            frame_start <= 1'b0;
        end else begin
            ACTIVE      <= pix_ready;
            HSYNC       <= (live && hs) ? SYNC_ON : ~SYNC_ON;
            VSYNC       <= (live && vs) ? SYNC_ON : ~SYNC_ON;
            x_pos       <= h_cnt;
            y_pos       <= v_cnt;
            frame_start <= live && (h_cnt == 11'd0) && (v_cnt == 11'd0);
        end
    end

    // Pixel capture: a missing pixel is shown as black and timing keeps
    // going; blanking is always black.
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            {red, green, blue} <= 24'd0;
        end else if (pix_ready && pix_valid) begin
            {red, green, blue} <= pix_data;
        end else begin
            {red, green, blue} <= 24'd0;
        end
    end

    // Sticky underrun; a new event takes priority over the clear
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (pix_ready && !pix_valid) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hdmi_video_timing_ctrl.sv
module tb_hdmi_video_timing_ctrl;

    localparam int HA = 12;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        pixclk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        HSYNC;
    logic        VSYNC;
    logic        ACTIVE;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [10:0] x_pos;
    logic [10:0] y_pos;
    logic        frame_start;
    logic        underrun;
    logic        underrun_clr;

    hdmi_video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(0)
    ) dut (
        .pixclk      (pixclk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .HSYNC       (HSYNC),
        .VSYNC       (VSYNC),
        .ACTIVE      (ACTIVE),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .frame_start (frame_start),
        .underrun    (underrun),
        .underrun_clr(underrun_clr)
    );

    always #5 pixclk = ~pixclk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_xfer  = 0;
    int n_fs    = 0;

    // Reference model: frame position as one linear index plus a run mode
    // (0 = idle, 1 = running, 2 = finishing the frame).
    int          m_mode;
    int          m_p;
    logic        e_active;
    logic        e_hs;
    logic        e_vs;
    logic        e_fs;
    logic        e_und;
    logic [23:0] e_rgb;
    int          e_x;
    int          e_y;
    logic [23:0] dcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_p    = 0;
        e_und  = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_active"}, 32'(ACTIVE), 32'd0);
        chk({tag, "_hsync"}, 32'(HSYNC), 32'd1);
        chk({tag, "_vsync"}, 32'(VSYNC), 32'd1);
        chk({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
        chk({tag, "_x"}, 32'(x_pos), 32'd0);
        chk({tag, "_y"}, 32'(y_pos), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_und"}, 32'(underrun), 32'd0);
        chk({tag, "_ready"}, 32'(pix_ready), 32'd0);
    endtask

    task automatic check_outputs();
        chk("active", 32'(ACTIVE), 32'(e_active));
        chk("hsync", 32'(HSYNC), 32'(e_hs));
        chk("vsync", 32'(VSYNC), 32'(e_vs));
        chk("rgb", 32'({red, green, blue}), 32'(e_rgb));
        chk("x_pos", 32'(x_pos), 32'(e_x));
        chk("y_pos", 32'(y_pos), 32'(e_y));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("underrun", 32'(underrun), 32'(e_und));
    endtask

    // One pixel clock: drive inputs on the falling edge, predict, check the
    // registered outputs just after the rising edge.
    task automatic cycle(input logic en, input logic vld, input logic [23:0] d, input logic clr);
        int   x;
        int   y;
        logic live;
        logic de;
        @(negedge pixclk);
        enable       = en;
        pix_valid    = vld;
        pix_data     = d;
        underrun_clr = clr;
        #1;
        x    = m_p % HT;
        y    = m_p / HT;
        live = (m_mode != 0);
        de   = live && (x < HA) && (y < VA);
        chk("pix_ready", 32'(pix_ready), 32'(de));
        if (pix_ready && pix_valid) n_xfer++;
        e_active = de;
        e_hs     = (live && x >= HA + HF && x < HA + HF + HS) ? 1'b0 : 1'b1;
        e_vs     = (live && y >= VA + VF && y < VA + VF + VS) ? 1'b0 : 1'b1;
        e_x      = x;
        e_y      = y;
        e_fs     = live && (m_p == 0);
        e_rgb    = (de && vld) ? d : 24'd0;
        if (de && !vld) e_und = 1'b1;
        else if (clr)   e_und = 1'b0;
        case (m_mode)
            0: begin
                m_p    = 0;
                m_mode = en ? 1 : 0;
            end
            1: begin
                m_p    = (m_p + 1) % FT;
                m_mode = en ? 1 : 2;
            end
            default: begin
                if (m_p == FT - 1) begin
                    m_p    = 0;
                    m_mode = 0;
                end else begin
                    m_p = m_p + 1;
                end
            end
        endcase
        @(posedge pixclk);
        #1;
        check_outputs();
        if (frame_start) n_fs++;
    endtask

    initial begin
        logic v;
        logic c;
        logic seen;

        rst_n        = 1'b0;
        enable       = 1'b1;
        pix_valid    = 1'b1;
        pix_data     = 24'd0;
        underrun_clr = 1'b0;
        dcnt         = 24'd1;
        model_reset();

        // Reset held with enable high
        repeat (3) @(posedge pixclk);
        #1;
        check_reset("rst_hold");

        // Release: first ACTIVE two edges after release, at (0,0) with frame_start
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, 24'h111111, 1'b0);
        chk("rel_edge1_active", 32'(ACTIVE), 32'd0);
        cycle(1'b1, 1'b1, 24'h222222, 1'b0);
        chk("rel_edge2_active", 32'(ACTIVE), 32'd1);
        chk("rel_edge2_fs", 32'(frame_start), 32'd1);
        chk("rel_edge2_xy", 32'({x_pos, y_pos}), 32'd0);
        chk("rel_edge2_rgb", 32'({red, green, blue}), 32'h222222);

        // Full frame with incrementing data and pix_valid always high
        for (int i = 0; i < 2 * FT && !(m_mode == 1 && m_p == 0); i++) begin
            cycle(1'b1, 1'b1, dcnt, 1'b0);
            dcnt++;
        end
        n_xfer = 0;
        n_fs   = 0;
        for (int i = 0; i < FT; i++) begin
            cycle(1'b1, 1'b1, dcnt, 1'b0);
            dcnt++;
        end
        chk("xfers_per_frame", 32'(n_xfer), 32'(HA * VA));
        chk("fs_per_frame", 32'(n_fs), 32'd1);

        // Random valid gaps, random data, occasional clears
        for (int i = 0; i < 2 * FT; i++) begin
            v = ($urandom_range(0, 7) != 0);
            c = ($urandom_range(0, 15) == 0);
            cycle(1'b1, v, 24'($urandom), c);
        end

        // Directed underrun at x=5, y=2
        for (int i = 0; i < 2 * FT && !(m_mode == 1 && m_p == 2 * HT + 5); i++)
            cycle(1'b1, 1'b1, 24'($urandom), 1'b1);
        chk("und_before", 32'(underrun), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 24'hABCDEF, 1'b0);
            chk("und_gap_rgb", 32'({red, green, blue}), 32'd0);
            chk("und_gap_x", 32'(x_pos), 32'(5 + i));
            chk("und_gap_flag", 32'(underrun), 32'd1);
        end
        cycle(1'b1, 1'b1, 24'h123456, 1'b0);
        chk("und_sticky", 32'(underrun), 32'd1);
        cycle(1'b1, 1'b0, 24'h123456, 1'b1);
        chk("und_set_wins", 32'(underrun), 32'd1);
        cycle(1'b1, 1'b1, 24'h654321, 1'b1);
        chk("und_clr", 32'(underrun), 32'd0);

        // Drop enable mid-frame: frame completes, then idle
        for (int i = 0; i < 2 * FT && !(m_mode == 1 && m_p == 3 * HT + 4); i++)
            cycle(1'b1, 1'b1, 24'($urandom), 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 2 * FT && !seen; i++) begin
            cycle(1'b0, 1'b1, 24'($urandom), 1'b0);
            if (x_pos == 11'(HT - 1) && y_pos == 11'(VT - 1)) seen = 1'b1;
        end
        chk("drain_end_seen", 32'(seen), 32'd1);
        cycle(1'b0, 1'b1, 24'h777777, 1'b0);
        chk("idle_x", 32'(x_pos), 32'd0);
        chk("idle_active", 32'(ACTIVE), 32'd0);
        chk("idle_fs", 32'(frame_start), 32'd0);
        cycle(1'b0, 1'b1, 24'h777777, 1'b0);
        chk("idle_hold_rgb", 32'({red, green, blue}), 32'd0);

        // Restart, then re-enable while finishing a frame
        for (int i = 0; i < HT * 2 + 3; i++)
            cycle(1'b1, 1'b1, 24'($urandom), 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 24'($urandom), 1'b0);
        for (int i = 0; i < 2 * FT; i++) begin
            v = ($urandom_range(0, 9) != 0);
            cycle(1'b1, v, 24'($urandom), 1'b0);
        end

        // Asynchronous reset mid-line
        for (int i = 0; i < 2 * FT && !(m_mode == 1 && (m_p % HT) == HA / 2); i++)
            cycle(1'b1, 1'b0, 24'($urandom), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        model_reset();
        repeat (2) @(posedge pixclk);
        #1;
        check_reset("rst_mid_hold");
        rst_n = 1'b1;
        for (int i = 0; i < FT + 5; i++) begin
            v = ($urandom_range(0, 3) != 0);
            cycle(1'b1, v, 24'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
